// File: rtl/timer_pkg.sv
// Shared definitions for the output-compare scheduler: default sizes and the
// head-of-queue decode result.
// No ports; imported by compare_scheduler and sched_fifo users.
package timer_pkg;

  // Default counter / timestamp width in bits.
  localparam int CNT_W_DEF = 32;
  // Default queue depth (power of two, minimum 2).
  localparam int DEPTH_DEF = 4;
  // Queue pointer width for the default depth.
  localparam int PTR_W     = $clog2(DEPTH_DEF);

  // Outcome of comparing the queue head against the running counter.
  typedef enum logic [1:0] {
    HS_WAIT,
    HS_MATCH,
    HS_EXPIRED
  } head_status_t;

endpackage

// File: rtl/sched_fifo.sv
// In-order timestamp queue for the compare scheduler.
// Latency: a push is visible at the head (and in o_count) the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; flush empties the queue.
// Ports:
//   i_clk, i_rst         rising-edge clock, asynchronous active-high reset
//   i_push/i_dat         write request and data
//   i_pop                retire the head entry
//   i_flush              synchronous empty, overrides push and pop
//   o_head               data of the oldest entry (valid when !o_empty)
//   o_count              registered occupancy, 0..DEPTH
//   o_full, o_empty      status derived from o_count
module sched_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_dat,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Depth is a power of two, so the pointers wrap on their natural width.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read when counted as valid.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/compare_scheduler.sv
// Output-compare scheduler: fires a one-cycle event when a free-running counter
// reaches the timestamp at the head of an in-order queue; past entries retire as missed.
// Latency: event_out rises the cycle after counter_out equals the head timestamp.
// Backpressure: wr_ready_out drops when the queue is full (registered occupancy only).
// Optional feature macro COMPARE_TOGGLE_EN adds toggle_out, which flips on every event.
// Ports:
//   clk_in, rst_in        rising-edge clock, asynchronous active-high reset
//   run_in                counter increments and head is evaluated while high
//   clear_in              synchronous counter zero, queue flush, missed clear
//   wr_valid_in/wr_time_in/wr_ready_out   timestamp push handshake
//   counter_out           current counter value
//   event_out             one-cycle pulse on a scheduled match
//   event_time_out        timestamp of the last fired entry
//   pending_out           number of queued entries
//   missed_out            sticky: an entry expired without firing
//   toggle_out            (COMPARE_TOGGLE_EN only) inverts with each event
module compare_scheduler
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     run_in,
  input  logic                     clear_in,
  input  logic                     wr_valid_in,
  input  logic [CNT_W-1:0]         wr_time_in,
  output logic                     wr_ready_out,
  output logic [CNT_W-1:0]         counter_out,
  output logic                     event_out,
  output logic [CNT_W-1:0]         event_time_out,
  output logic [$clog2(DEPTH):0]   pending_out,
  output logic                     missed_out
`ifdef COMPARE_TOGGLE_EN
  ,
  output logic                     toggle_out
`endif
);

  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_event_time;
  logic                   r_event;
  logic                   r_missed;

  logic [CNT_W-1:0]       w_head;
  logic [CNT_W-1:0]       w_diff;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  head_status_t           w_status;

  sched_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (clear_in),
    .i_dat   (wr_time_in),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Modular distance to the head: MSB set means the target is in the past,
  // which keeps the decision correct across counter wrap.
  assign w_diff = w_head - r_cnt;

  always_comb begin
    w_status = HS_WAIT;
    if (!w_empty && run_in && !clear_in) begin
      if (w_diff == '0)
        w_status = HS_MATCH;
      else if (w_diff[CNT_W-1])
        w_status = HS_EXPIRED;
    end
  end

  assign w_pop  = (w_status != HS_WAIT);
  assign w_push = wr_valid_in & ~w_full & ~clear_in;

  // Ready is held low while reset is asserted so every output reads 0 then.
  assign wr_ready_out = ~w_full & ~rst_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt        <= '0;
      r_event      <= 1'b0;
      r_event_time <= '0;
      r_missed     <= 1'b0;
    end else if (clear_in) begin
      // event_time is deliberately kept across a clear.
      r_cnt    <= '0;
      r_event  <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      if (run_in) r_cnt <= r_cnt + 1'b1;
      r_event <= (w_status == HS_MATCH);
      if (w_status == HS_MATCH)   r_event_time <= w_head;
      if (w_status == HS_EXPIRED) r_missed     <= 1'b1;
    end
  end

`ifdef COMPARE_TOGGLE_EN
  logic r_toggle;

  // Flips on the same edge that raises event_out; clear leaves it alone.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_toggle <= 1'b0;
    else if (w_status == HS_MATCH)
      r_toggle <= ~r_toggle;
  end

  assign toggle_out = r_toggle;
`endif

  assign counter_out    = r_cnt;
  assign event_out      = r_event;
  assign event_time_out = r_event_time;
  assign pending_out    = w_count;
  assign missed_out     = r_missed;

endmodule

// File: tb/tb_compare_scheduler.sv
// Directed bench for compare_scheduler with an 8-bit counter so that the
// wrap case is reachable by simply running the counter.
module tb_compare_scheduler;

  localparam int CW = 8;
  localparam int DP = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          run_in;
  logic          clear_in;
  logic          wr_valid_in;
  logic [CW-1:0] wr_time_in;
  logic          wr_ready_out;
  logic [CW-1:0] counter_out;
  logic          event_out;
  logic [CW-1:0] event_time_out;
  logic [2:0]    pending_out;
  logic          missed_out;
`ifdef COMPARE_TOGGLE_EN
  logic          toggle_out;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Every event seen: its reported timestamp and the counter value alongside it.
  logic [CW-1:0] ev_time_q [$];
  logic [CW-1:0] ev_cnt_q  [$];

  compare_scheduler #(
    .CNT_W (CW),
    .DEPTH (DP)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .run_in         (run_in),
    .clear_in       (clear_in),
    .wr_valid_in    (wr_valid_in),
    .wr_time_in     (wr_time_in),
    .wr_ready_out   (wr_ready_out),
    .counter_out    (counter_out),
    .event_out      (event_out),
    .event_time_out (event_time_out),
    .pending_out    (pending_out),
    .missed_out     (missed_out)
`ifdef COMPARE_TOGGLE_EN
    ,
    .toggle_out     (toggle_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; log any event pulse.
  task automatic step();
    @(posedge clk_in);
    #1;
    if (event_out) begin
      ev_time_q.push_back(event_time_out);
      ev_cnt_q.push_back(counter_out);
    end
  endtask

  // Run until counter_out reaches v, bounded.
  task automatic wait_cnt(input logic [CW-1:0] v);
    int k = 0;
    while (counter_out != v && k < 400) begin
      step();
      k++;
    end
    chk("wait_cnt", 32'(counter_out), 32'(v));
  endtask

  initial begin
    logic [CW-1:0] exp_t [4];
    exp_t[0] = 8'd20; exp_t[1] = 8'd30; exp_t[2] = 8'd40; exp_t[3] = 8'd50;

    rst_in      = 1'b1;
    run_in      = 1'b0;
    clear_in    = 1'b0;
    wr_valid_in = 1'b0;
    wr_time_in  = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_counter",   32'(counter_out), 0);
    chk("rst_pending",   32'(pending_out), 0);
    chk("rst_event",     32'(event_out), 0);
    chk("rst_evtime",    32'(event_time_out), 0);
    chk("rst_missed",    32'(missed_out), 0);
    chk("rst_ready",     32'(wr_ready_out), 0);
    rst_in = 1'b0;
    #1;
    chk("ready_after_rst", 32'(wr_ready_out), 1);

    // ---- basic fire: push 10 at cnt 2 ----
    run_in = 1'b1;
    wait_cnt(8'd2);
    wr_valid_in = 1'b1; wr_time_in = 8'd10;
    step();
    wr_valid_in = 1'b0;
    chk("basic_pending1", 32'(pending_out), 1);
    repeat (12) step();
    chk("basic_nev",     ev_time_q.size(), 1);
    chk("basic_time",    32'(ev_time_q[0]), 10);
    chk("basic_cnt",     32'(ev_cnt_q[0]), 11);
    chk("basic_pending0", 32'(pending_out), 0);
    chk("basic_missed",  32'(missed_out), 0);

    // ---- full / backpressure ----
    clear_in = 1'b1; run_in = 1'b0;
    step();
    clear_in = 1'b0;
    chk("clr_counter", 32'(counter_out), 0);
    chk("clr_pending", 32'(pending_out), 0);
    wr_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_time_in = exp_t[i];
      step();
    end
    chk("full_pending", 32'(pending_out), 4);
    chk("full_ready",   32'(wr_ready_out), 0);
    wr_time_in = 8'd60;
    step();
    wr_valid_in = 1'b0;
    chk("full_drop_pending", 32'(pending_out), 4);
    ev_time_q.delete(); ev_cnt_q.delete();
    run_in = 1'b1;
    repeat (70) step();
    chk("full_nev", ev_time_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("full_time", 32'(ev_time_q[i]), 32'(exp_t[i]));
      chk("full_cnt",  32'(ev_cnt_q[i]),  32'(exp_t[i]) + 1);
    end
    chk("full_pending0", 32'(pending_out), 0);
    chk("full_missed",   32'(missed_out), 0);

    // ---- expired entry, then clear ----
    ev_time_q.delete(); ev_cnt_q.delete();
    wait_cnt(8'd100);
    wr_valid_in = 1'b1; wr_time_in = 8'd50;
    step();
    wr_valid_in = 1'b0;
    chk("exp_pending1", 32'(pending_out), 1);
    chk("exp_missed_early", 32'(missed_out), 0);
    step();
    chk("exp_missed",   32'(missed_out), 1);
    chk("exp_pending0", 32'(pending_out), 0);
    chk("exp_nev",      ev_time_q.size(), 0);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    chk("clr2_counter", 32'(counter_out), 0);
    chk("clr2_missed",  32'(missed_out), 0);
    chk("clr2_evtime",  32'(event_time_out), 50);
    chk("clr2_event",   32'(event_out), 0);

    // ---- wrap: push 1 at cnt 253 ----
    ev_time_q.delete(); ev_cnt_q.delete();
    wait_cnt(8'd253);
    wr_valid_in = 1'b1; wr_time_in = 8'd1;
    step();
    wr_valid_in = 1'b0;
    repeat (10) step();
    chk("wrap_nev",     ev_time_q.size(), 1);
    chk("wrap_time",    32'(ev_time_q[0]), 1);
    chk("wrap_cnt",     32'(ev_cnt_q[0]), 2);
    chk("wrap_missed",  32'(missed_out), 0);
    chk("wrap_pending", 32'(pending_out), 0);

    // ---- duplicates with push during pop ----
    ev_time_q.delete(); ev_cnt_q.delete();
    wait_cnt(8'd60);
    wr_valid_in = 1'b1; wr_time_in = 8'd70;
    step();
    step();
    wr_valid_in = 1'b0;
    chk("dup_pending2", 32'(pending_out), 2);
    wait_cnt(8'd70);
    wr_valid_in = 1'b1; wr_time_in = 8'd80;
    step();
    wr_valid_in = 1'b0;
    chk("dup_event",     32'(event_out), 1);
    chk("dup_evtime",    32'(event_time_out), 70);
    chk("dup_pend_swap", 32'(pending_out), 2);
    chk("dup_missed0",   32'(missed_out), 0);
    step();
    chk("dup_event2",    32'(event_out), 0);
    chk("dup_missed1",   32'(missed_out), 1);
    chk("dup_pending1",  32'(pending_out), 1);
    repeat (15) step();
    chk("dup_nev",      ev_time_q.size(), 2);
    chk("dup_t80",      32'(ev_time_q[1]), 80);
    chk("dup_c81",      32'(ev_cnt_q[1]), 81);
    chk("dup_pending0", 32'(pending_out), 0);

    // ---- asynchronous reset with entries pending ----
    run_in = 1'b0;
    wr_valid_in = 1'b1;
    wr_time_in = 8'd100; step();
    wr_time_in = 8'd110; step();
    wr_time_in = 8'd120; step();
    wr_valid_in = 1'b0;
    chk("ar_pending3", 32'(pending_out), 3);
    ev_time_q.delete(); ev_cnt_q.delete();
    #3 rst_in = 1'b1;
    #1;
    chk("ar_counter", 32'(counter_out), 0);
    chk("ar_pending", 32'(pending_out), 0);
    chk("ar_missed",  32'(missed_out), 0);
    chk("ar_evtime",  32'(event_time_out), 0);
    chk("ar_event",   32'(event_out), 0);
    chk("ar_ready",   32'(wr_ready_out), 0);
    #2 rst_in = 1'b0;
    run_in = 1'b1;
    repeat (40) step();
    chk("ar_nev",      ev_time_q.size(), 0);
    chk("ar_pending0", 32'(pending_out), 0);
    chk("ar_ready1",   32'(wr_ready_out), 1);
    chk("ar_count40",  32'(counter_out), 40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
